tone_period_meter: RTL and testbench

- Receive-side counterpart to the speaker tone generators.
- Samples an asynchronous square-wave input, for example a comparator on a microphone or a loopback of a speaker pin.
- Measures the full period in system-clock cycles between rising edges.
- Reports each period with a one-cycle valid strobe, flags silence, and classifies pitch movement as rising, falling or steady, which is enough to decode sweeping sirens and beeps.

---
 rtl/tone_period_meter.sv | 146 ++++++++++++++
 tb/tb_tone_period_meter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tone_period_meter.sv
// Tone period meter: measures the full period of an asynchronous square wave
// in clk cycles between accepted rising edges, strobes each new period,
// flags silence and classifies pitch movement (rising / falling / steady).
//
// Ports:
//   clk          system clock
//   resetn       synchronous active-low reset
//   tone_in      asynchronous square-wave input
//   period       last accepted full period in clk cycles
//   period_valid one-cycle strobe when period updates
//   silent       high while no valid tone is present
//   sweep_up     last period shorter than previous by more than HYST
//   sweep_down   last period longer than previous by more than HYST
module tone_period_meter #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MIN_PERIOD = 64,
  parameter int unsigned TIMEOUT    = 65535,
  parameter int unsigned HYST       = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             silent,
  output logic             sweep_up,
  output logic             sweep_down
);

  localparam int unsigned EXT_W = CNT_W + 1;

  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_M1  = CNT_W'(TIMEOUT - 1);
  localparam logic [EXT_W-1:0] HYST_X  = EXT_W'(HYST);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           state, state_d;
  logic             s1, s2, s3;
  logic             rise_c;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] prev, prev_d;
  logic             have_prev, have_prev_d;
  logic [CNT_W-1:0] period_d;
  logic             period_valid_d, silent_d, sweep_up_d, sweep_down_d;
  logic [EXT_W-1:0] new_x, prev_x;
  logic             faster_c, slower_c;

  // Two-flop synchroniser plus history flop for edge detection
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tone_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_c = s2 & ~s3;

  // Sweep compare in one extra bit so the +HYST terms cannot wrap
  assign new_x    = EXT_W'(cnt);
  assign prev_x   = EXT_W'(prev);
  assign faster_c = have_prev && ((new_x + HYST_X) < prev_x);
  assign slower_c = have_prev && !faster_c && (new_x > (prev_x + HYST_X));

  // Next-state and next-output logic
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    prev_d         = prev;
    have_prev_d    = have_prev;
    period_d       = period;
    period_valid_d = 1'b0;
    silent_d       = silent;
    sweep_up_d     = sweep_up;
    sweep_down_d   = sweep_down;

    case (state)
      IDLE: begin
        if (rise_c) begin
          cnt_d   = CNT_W'(1);
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (cnt != TMO) begin
          cnt_d = cnt + CNT_W'(1);
        end
        if (rise_c && (cnt >= MIN_P)) begin
          period_d       = cnt;
          period_valid_d = 1'b1;
          cnt_d          = CNT_W'(1);
          silent_d       = 1'b0;
          sweep_up_d     = faster_c;
          sweep_down_d   = slower_c;
          prev_d         = cnt;
          have_prev_d    = 1'b1;
        end else if (!rise_c && (cnt == TMO_M1)) begin
          // No accepted edge for too long: drop the reference and go quiet
          silent_d     = 1'b1;
          sweep_up_d   = 1'b0;
          sweep_down_d = 1'b0;
          have_prev_d  = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      prev         <= '0;
      have_prev    <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      silent       <= 1'b1;
      sweep_up     <= 1'b0;
      sweep_down   <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      prev         <= prev_d;
      have_prev    <= have_prev_d;
      period       <= period_d;
      period_valid <= period_valid_d;
      silent       <= silent_d;
      sweep_up     <= sweep_up_d;
      sweep_down   <= sweep_down_d;
    end
  end

endmodule

// File: tb/tb_tone_period_meter.sv
// Testbench for tone_period_meter: directed and randomized square waves,
// a cycle-accurate behavioural model, and literal checkpoints.
module tb_tone_period_meter;

  localparam int unsigned CW   = 16;
  localparam int unsigned MINP = 64;
  localparam int unsigned TMO  = 1500;
  localparam int unsigned HY   = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          tone_in;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          silent;
  logic          sweep_up;
  logic          sweep_down;

  always #5 clk = ~clk;

  tone_period_meter #(
    .CNT_W(CW), .MIN_PERIOD(MINP), .TIMEOUT(TMO), .HYST(HY)
  ) dut (
    .clk(clk), .resetn(resetn), .tone_in(tone_in), .period(period),
    .period_valid(period_valid), .silent(silent),
    .sweep_up(sweep_up), .sweep_down(sweep_down)
  );

  int     vectors = 0;
  int     miscompares = 0;
  longint now = 0;
  bit     checking = 0;
  int     strobes = 0;

  // Model state: sampled input history, time of last accepted edge, outputs
  bit     x1, x2, x3;
  bit     m_meas, m_have_prev;
  longint m_last;
  longint m_prev;
  longint m_period;
  bit     m_valid, m_silent, m_up, m_down;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, now, act, exp);
    end
  endtask

  // Outputs after the clk edge at which tone t and reset r were sampled.
  // A rise becomes visible to the meter three edges after it is sampled.
  task automatic model_edge(input bit t, input bit r);
    bit     rise;
    longint el;
    now++;
    if (!r) begin
      x1 = 0; x2 = 0; x3 = 0;
      m_meas = 0; m_have_prev = 0; m_period = 0;
      m_valid = 0; m_silent = 1; m_up = 0; m_down = 0;
      return;
    end
    rise = x2 && !x3;
    x3 = x2; x2 = x1; x1 = t;
    m_valid = 0;
    if (!m_meas) begin
      if (rise) begin
        m_meas = 1;
        m_last = now;
      end
    end else begin
      el = now - m_last;
      if (rise && el >= MINP) begin
        m_valid  = 1;
        m_period = el;
        m_silent = 0;
        m_up     = m_have_prev && (el + HY < m_prev);
        m_down   = m_have_prev && (el > m_prev + HY);
        m_prev   = el;
        m_have_prev = 1;
        m_last   = now;
      end else if (!rise && el == TMO - 1) begin
        m_meas = 0; m_silent = 1; m_up = 0; m_down = 0; m_have_prev = 0;
      end
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (checking) begin
      chk("period", 32'(period), 32'(m_period));
      chk("period_valid", 32'(period_valid), 32'(m_valid));
      chk("silent", 32'(silent), 32'(m_silent));
      chk("sweep_up", 32'(sweep_up), 32'(m_up));
      chk("sweep_down", 32'(sweep_down), 32'(m_down));
    end
  end

  task automatic step(input bit t, input bit r);
    tone_in = t;
    resetn  = r;
    @(posedge clk);
    model_edge(t, r);
    checking = 1;
    #1;
    if (period_valid === 1'b1) strobes++;
  endtask

  task automatic hold(input bit t, input int n);
    repeat (n) step(t, 1'b1);
  endtask

  task automatic tone(input int p, input int h);
    hold(1'b1, h);
    hold(1'b0, p - h);
  endtask

  // Start a period of length p; shortly after its rise, pin the just-ended one
  task automatic tone_chk(input int p, input int ep, input bit eu, input bit ed);
    hold(1'b1, 20);
    chk("lit_period", 32'(period), 32'(ep));
    chk("lit_up", 32'(sweep_up), 32'(eu));
    chk("lit_down", 32'(sweep_down), 32'(ed));
    hold(1'b0, p - 20);
  endtask

  initial begin
    int p, h;
    // Reset held with the input toggling
    for (int i = 0; i < 20; i++) step(bit'(i % 2), 1'b0);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_silent", 32'(silent), 32'd1);
    chk("rst_valid", 32'(period_valid), 32'd0);
    hold(1'b0, 10);

    // Steady tone: first rise gives nothing, then one strobe per period
    strobes = 0;
    tone(500, 250);
    chk("first_rise_strobes", 32'(strobes), 32'd0);
    chk("first_rise_silent", 32'(silent), 32'd1);
    repeat (5) tone(500, 250);
    chk("steady_strobes", 32'(strobes), 32'd5);
    chk("steady_period", 32'(period), 32'd500);
    chk("steady_silent", 32'(silent), 32'd0);

    // Sweep classification incl. the HYST boundary
    tone_chk(400, 500, 0, 0);
    tone_chk(410, 400, 1, 0);
    tone_chk(600, 410, 0, 0);
    tone_chk(500, 600, 0, 1);
    tone_chk(484, 500, 1, 0);
    tone_chk(500, 484, 0, 0);
    tone_chk(483, 500, 0, 0);
    tone_chk(500, 483, 1, 0);

    // Glitch pulse 30 cycles after a rise is ignored
    hold(1'b1, 10); hold(1'b0, 20); hold(1'b1, 1); hold(1'b0, 500 - 31);
    tone_chk(500, 500, 0, 0);

    // Silence timeout: flags cleared, period retained
    hold(1'b0, TMO);
    chk("tmo_silent", 32'(silent), 32'd1);
    chk("tmo_period", 32'(period), 32'd500);
    chk("tmo_up", 32'(sweep_up), 32'd0);
    chk("tmo_down", 32'(sweep_down), 32'd0);
    strobes = 0;
    tone(500, 250);
    chk("restart_strobes0", 32'(strobes), 32'd0);
    tone_chk(1499, 500, 0, 0);
    chk("restart_strobes1", 32'(strobes), 32'd1);
    chk("restart_silent", 32'(silent), 32'd0);
    // Rise exactly at the timeout count wins
    tone_chk(64, 1499, 0, 1);
    chk("coincide_silent", 32'(silent), 32'd0);

    // MIN_PERIOD boundary: 64 accepted, 63 rejected
    tone_chk(200, 64, 1, 0);
    tone(63, 10);
    tone(63, 10);
    tone_chk(300, 126, 1, 0);

    // Reset mid-period discards history
    hold(1'b1, 100); hold(1'b0, 100);
    step(1'b0, 1'b0);
    chk("mid_rst_period", 32'(period), 32'd0);
    chk("mid_rst_silent", 32'(silent), 32'd1);
    strobes = 0;
    hold(1'b0, 50);
    tone(400, 200);
    chk("mid_rst_strobes0", 32'(strobes), 32'd0);
    tone_chk(400, 400, 0, 0);
    chk("mid_rst_strobes1", 32'(strobes), 32'd1);

    // Randomized tones, glitches, gaps and resets against the model
    for (int i = 0; i < 40; i++) begin
      p = int'($urandom_range(1100, 20));
      h = int'($urandom_range(p - 1, 1));
      tone(p, h);
      if ($urandom_range(9, 0) == 0) hold(1'b0, 1600);
      if ($urandom_range(14, 0) == 0) begin
        hold(1'b0, int'($urandom_range(30, 1)));
        step(1'(($urandom_range(1, 0))), 1'b0);
      end
    end
    hold(1'b0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
